// File: rtl/gf_pkg.sv
// Shared GF(2^13) constants, FSM state encoding and coefficient helper
// for the radix-conversion / twist blocks around the additive FFT.
package gf_pkg;

  localparam int             GF_M         = 13;
  localparam logic [12:0]    GF_POLY      = 13'h001B;  // x^13 + x^4 + x^3 + x + 1
  localparam logic [12:0]    GF_BETA_INV  = 13'h0002;
  localparam int             NUM_DEF      = 64;
  localparam int             L_DEF        = $clog2(NUM_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IRC,
    S_UNTWIST,
    S_FIN
  } state_t;

  // Extract coefficient i from a packed bus of NUM_DEF coefficients.
  function automatic logic [GF_M-1:0] coeff_of(input logic [NUM_DEF*GF_M-1:0] bus,
                                               input int i);
    return bus[i*GF_M +: GF_M];
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier: carry-less product reduced mod x^M + POLY.
module gf_mul
  import gf_pkg::*;
#(
  parameter int          M    = GF_M,
  parameter logic [M-1:0] POLY = GF_POLY
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic [M-1:0] y_o
);

  logic [M-1:0] acc;

  // Horner evaluation from the MSB of b: acc = acc*x + b[i]*a, reducing each step.
  always_comb begin
    // NOTE: every variable an always_comb writes gets a value on every path
    // before use; that is what keeps it combinational instead of a latch.
    acc = '0;
    for (int i = M - 1; i >= 0; i--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0) ^ (b_i[i] ? a_i : '0);
    end
    y_o = acc;
  end

endmodule

// File: rtl/rad_conv_untwist.sv
// Inverse radix conversion (Taylor / (x^2+x) basis back to monomials)
// followed by removal of the twist: coefficient i is scaled by BETA_INV^i.
module rad_conv_untwist
  import gf_pkg::*;
#(
  parameter int           M        = GF_M,
  parameter int           NUM      = NUM_DEF,
  parameter logic [M-1:0] POLY     = GF_POLY,
  parameter logic [M-1:0] BETA_INV = GF_BETA_INV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM*M-1:0] coeff_in,
  output logic [NUM*M-1:0] coeff_out,
  output logic             busy,
  output logic             done
);

  localparam int L     = $clog2(NUM);
  localparam int LVL_W = $clog2(L);

  state_t           state_q;
  logic [M-1:0]     c_q   [NUM];
  logic [M-1:0]     irc_d [NUM];
  logic [LVL_W-1:0] lvl_q;
  logic             sub_q;
  logic [L-1:0]     k_q;
  logic [M-1:0]     p_q;
  logic [M-1:0]     p_d;
  logic [M-1:0]     prod_d;
  logic [NUM*M-1:0] out_q;
  logic             busy_q;
  logic             done_q;

  // Scaled coefficient c[k] * BETA_INV^k for the untwist step.
  gf_mul #(.M(M), .POLY(POLY)) u_mul_data (
    .a_i (c_q[k_q]),
    .b_i (p_q),
    .y_o (prod_d)
  );

  // Next power of the inverse twist constant.
  gf_mul #(.M(M), .POLY(POLY)) u_mul_pow (
    .a_i (p_q),
    .b_i (BETA_INV),
    .y_o (p_d)
  );

  // One IRC sub-step: within each 4s block, position-1 quarter (sub 0) or
  // position-2 quarter (sub 1) absorbs the quarter just above it; s = 2^lvl.
  always_comb begin
    for (int i = 0; i < NUM; i++) irc_d[i] = c_q[i];
    for (int lv = 0; lv < L - 1; lv++) begin
      if (lvl_q == LVL_W'(lv)) begin
        for (int i = 0; i < NUM; i++) begin
          if (((i >> lv) & 3) == (sub_q ? 2 : 1))
            irc_d[i] = c_q[i] ^ c_q[(i + (1 << lv)) % NUM];
        end
      end
    end
  end

  // Sequencer: load, IRC levels, per-coefficient untwist, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the working array is cleared on reset as well, so an aborted run
      // leaves no partial data behind; this costs reset fan-out on every bit.
      for (int i = 0; i < NUM; i++) c_q[i] <= '0;
      lvl_q   <= '0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      p_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every update in this
      // block sees the pre-edge values of all registers.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM; i++) c_q[i] <= coeff_in[i*M +: M];
            lvl_q   <= '0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_IRC;
          end
        end
        S_IRC: begin
          for (int i = 0; i < NUM; i++) c_q[i] <= irc_d[i];
          sub_q <= ~sub_q;
          if (sub_q) begin
            if (lvl_q == LVL_W'(L - 2)) begin
              k_q     <= '0;
              p_q     <= M'(1);
              state_q <= S_UNTWIST;
            end else begin
              lvl_q <= lvl_q + 1'b1;
            end
          end
        end
        S_UNTWIST: begin
          c_q[k_q] <= prod_d;
          p_q      <= p_d;
          if (k_q == L'(NUM - 1)) state_q <= S_FIN;
          else                    k_q     <= k_q + 1'b1;
        end
        S_FIN: begin
          for (int i = 0; i < NUM; i++) out_q[i*M +: M] <= c_q[i];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coeff_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rad_conv_untwist.sv
// Self-checking bench for rad_conv_untwist. Expected results come from a
// polynomial-level model: the forward twist + Taylor expansion is computed by
// back-substitution against the basis x^(i&1) * (x^2+x)^(i>>1).
module tb_rad_conv_untwist;
  import gf_pkg::*;

  localparam int           M       = GF_M;
  localparam int           NUM     = NUM_DEF;
  localparam int           W       = NUM * M;
  localparam int           EXP_LAT = 75;
  localparam logic [M-1:0] BINV    = 13'h0002;

  typedef logic [W-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  vec_t coeff_in;
  vec_t coeff_out;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;
  logic [M-1:0] beta;

  always #5 clk = ~clk;

  rad_conv_untwist #(.M(M), .NUM(NUM), .POLY(GF_POLY), .BETA_INV(BINV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .coeff_in  (coeff_in),
    .coeff_out (coeff_out),
    .busy      (busy),
    .done      (done)
  );

  // Schoolbook product followed by long division by the full modulus.
  function automatic logic [M-1:0] gf_mul_ref(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ((2*M-1)'(a) << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ ((2*M-1)'({1'b1, GF_POLY}) << (i - M));
    return p[M-1:0];
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NUM; i++) v[i*M +: M] = M'($urandom);
    return v;
  endfunction

  // Forward transform: twist by beta^k, then express in the (x^2+x) basis.
  function automatic vec_t forward_model(input vec_t f, input logic [M-1:0] b);
    logic [M-1:0] h [NUM];
    logic [M-1:0] pw;
    logic [M-1:0] gi;
    vec_t g;
    int n;
    int i0;
    pw = M'(1);
    for (int k = 0; k < NUM; k++) begin
      h[k] = gf_mul_ref(coeff_of(f, k), pw);
      pw   = gf_mul_ref(pw, b);
    end
    g = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      gi = h[i];
      g[i*M +: M] = gi;
      n  = i >> 1;
      i0 = i & 1;
      // x^i0 * x^n * (x+1)^n: term x^(i0+n+t) present iff t is a bit-subset of n.
      for (int t = 0; t <= n; t++)
        if ((t & n) == t) h[i0 + n + t] = h[i0 + n + t] ^ gi;
    end
    return g;
  endfunction

  function automatic int first_diff(input vec_t a, input vec_t b);
    for (int i = 0; i < NUM; i++)
      if (coeff_of(a, i) !== coeff_of(b, i)) return i;
    return -1;
  endfunction

  // Launch one operation; extra start pulses are sampled at edges t0+x1/x2/x3.
  task automatic run_op(input string tag, input vec_t vec, input int x1, input int x2,
                        input int x3, output vec_t res);
    int lat;
    bit busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    coeff_in = vec;
    start    = 1'b1;
    @(posedge clk); #1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      coeff_in = rand_vec();
      start    = (cyc == x1) || (cyc == x2) || (cyc == x3);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    checks++;
    if (lat != EXP_LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, EXP_LAT);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_during_op: busy dropped before done, expected held high", tag);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b, expected 0", tag, busy);
    end
    res = coeff_out;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    coeff_in = '0;
    #12;
    checks++;
    if (coeff_out !== '0) begin
      errors++;
      $display("FAIL reset_coeff_out: got nonzero at coeff %0d, expected all 0", first_diff(coeff_out, '0));
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero();
    vec_t res;
    run_op("zero", '0, -1, -1, -1, res);
    checks++;
    if (res !== '0) begin
      errors++;
      $display("FAIL zero_result: coeff %0d got %h, expected 0", first_diff(res, '0), coeff_of(res, first_diff(res, '0)));
    end
  endtask

  task automatic test_unit_vectors();
    vec_t vin;
    vec_t exp;
    vec_t res;
    int d;
    vin = '0; vin[0*M +: M] = 13'h0001;
    exp = '0; exp[0*M +: M] = 13'h0001;
    run_op("unit_c0", vin, -1, -1, -1, res);
    checks++;
    d = first_diff(res, exp);
    if (d >= 0) begin
      errors++;
      $display("FAIL unit_c0: coeff %0d got %h, expected %h", d, coeff_of(res, d), coeff_of(exp, d));
    end
    vin = '0; vin[2*M +: M] = 13'h0001;
    exp = '0; exp[1*M +: M] = 13'h0002; exp[2*M +: M] = 13'h0004;
    run_op("unit_c2", vin, -1, -1, -1, res);
    checks++;
    d = first_diff(res, exp);
    if (d >= 0) begin
      errors++;
      $display("FAIL unit_c2: coeff %0d got %h, expected %h", d, coeff_of(res, d), coeff_of(exp, d));
    end
  endtask

  task automatic test_round_trip();
    vec_t f;
    vec_t res;
    int d;
    for (int n = 0; n < 100; n++) begin
      f = rand_vec();
      run_op("round_trip", forward_model(f, beta), -1, -1, -1, res);
      checks++;
      d = first_diff(res, f);
      if (d >= 0) begin
        errors++;
        $display("FAIL round_trip[%0d]: coeff %0d got %h, expected %h", n, d, coeff_of(res, d), coeff_of(f, d));
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t f;
    vec_t res;
    int d;
    f = rand_vec();
    run_op("extra_start", forward_model(f, beta), 5, 74, 75, res);
    checks++;
    d = first_diff(res, f);
    if (d >= 0) begin
      errors++;
      $display("FAIL extra_start_result: coeff %0d got %h, expected %h", d, coeff_of(res, d), coeff_of(f, d));
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL extra_start_single_done: done=%b busy=%b, expected done=0 busy=0", done, busy);
    end
    f = rand_vec();
    run_op("after_done", forward_model(f, beta), -1, -1, -1, res);
    checks++;
    d = first_diff(res, f);
    if (d >= 0) begin
      errors++;
      $display("FAIL after_done_result: coeff %0d got %h, expected %h", d, coeff_of(res, d), coeff_of(f, d));
    end
  endtask

  task automatic test_reset_mid();
    vec_t f;
    vec_t res;
    bit seen_done;
    int d;
    f = rand_vec();
    @(negedge clk);
    coeff_in = forward_model(f, beta);
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (coeff_out !== '0) begin
      errors++;
      $display("FAIL mid_reset_coeff_out: coeff %0d nonzero, expected all 0", first_diff(coeff_out, '0));
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: busy=%b done=%b, expected 0 0", busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL mid_reset_no_done: activity seen after abort, expected idle");
    end
    f = rand_vec();
    run_op("post_reset", forward_model(f, beta), -1, -1, -1, res);
    checks++;
    d = first_diff(res, f);
    if (d >= 0) begin
      errors++;
      $display("FAIL post_reset_result: coeff %0d got %h, expected %h", d, coeff_of(res, d), coeff_of(f, d));
    end
  endtask

  initial begin
    beta = '0;
    for (int b = 1; b < (1 << M); b++)
      if (gf_mul_ref(M'(b), BINV) == M'(1)) beta = M'(b);
    test_reset();
    test_zero();
    test_unit_vectors();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
